// File: rtl/uart_boot_loader_pkg.sv
// rtl/uart_boot_loader_pkg.sv - shared state encodings and helpers for the UART boot loader
package uart_boot_loader_pkg;

  // Loader session states: two header bytes, payload, then a terminal state
  typedef enum logic [2:0] {
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  // Receiver framing states for one 8N1 character
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Width of the header length field in bits, plus one for overflow-safe compares
  localparam int LEN_CMP_W = 17;

  // Word index to instmem byte address (same space as pc)
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/uart_boot_loader_rx.sv
// rtl/uart_boot_loader_rx.sv - 8N1 UART receiver with input synchroniser and sticky framing flag
module uart_boot_loader_rx
  import uart_boot_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 2;
  localparam int HALF = DIV / 2;

  logic            sync1, rx_s;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_d, ferr_d;

  assign rx_byte = shift_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      frame_err  <= ferr_d;
    end
  end

  // Framing: confirm start at mid-bit, then sample each bit one period apart
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = frame_err;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) valid_d = 1'b1;
          else      ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - loads a length-prefixed word image over UART into instmem
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             core_reset,
  output logic             done,
  output logic             err,
  output logic             frame_err,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam logic [LEN_CMP_W-1:0] MAX_N = LEN_CMP_W'(MAX_WORDS);

  logic        byte_valid;
  logic [7:0]  rx_byte;
  ld_state_t   state_q, state_d;
  logic [15:0] len_q;
  logic [1:0]  lane_q;
  logic [23:0] asm_q;
  logic [15:0] len_full;
  logic        all_loaded;
  logic        take_data;

  uart_boot_loader_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst        (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  assign len_full   = {rx_byte, len_q[7:0]};
  assign all_loaded = LEN_CMP_W'(words_loaded) == {1'b0, len_q};
  assign take_data  = byte_valid && (state_q == LD_DATA) && !all_loaded;

  assign done       = (state_q == LD_DONE);
  assign err        = (state_q == LD_ERR);
  assign core_reset = (state_q != LD_DONE);

  // Loader state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LD_LEN_LO;
    else       state_q <= state_d;
  end

  // Session sequencing: header parse, payload, terminal states held until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_LEN_LO: if (byte_valid) state_d = LD_LEN_HI;
      LD_LEN_HI: begin
        if (byte_valid) begin
          if (len_full == 16'd0)              state_d = LD_DONE;
          else if ({1'b0, len_full} > MAX_N)  state_d = LD_ERR;
          else                                state_d = LD_DATA;
        end
      end
      LD_DATA:   if (all_loaded) state_d = LD_DONE;
      LD_DONE:   state_d = LD_DONE;
      LD_ERR:    state_d = LD_ERR;
      default:   state_d = LD_LEN_LO;
    endcase
  end

  // Header capture, little-endian word assembly and the instmem write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      lane_q       <= '0;
      asm_q        <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      words_loaded <= '0;
    end else begin
      im_we <= 1'b0;
      if (byte_valid && state_q == LD_LEN_LO) len_q[7:0]  <= rx_byte;
      if (byte_valid && state_q == LD_LEN_HI) len_q[15:8] <= rx_byte;
      if (take_data) begin
        lane_q <= lane_q + 1'b1;
        case (lane_q)
          2'd0: asm_q[7:0]   <= rx_byte;
          2'd1: asm_q[15:8]  <= rx_byte;
          2'd2: asm_q[23:16] <= rx_byte;
          default: begin
            im_we        <= 1'b1;
            im_addr      <= word_addr(32'(words_loaded));
            im_wdata     <= {rx_byte, asm_q};
            words_loaded <= words_loaded + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - randomized self-checking bench for uart_boot_loader
`timescale 1ns/1ps
module tb_uart_boot_loader;

  localparam int DIV   = 10;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx;
  logic             im_we;
  logic [31:0]      im_addr;
  logic [31:0]      im_wdata;
  logic             core_reset;
  logic             done;
  logic             err;
  logic             frame_err;
  logic [CNT_W-1:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  sent_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          done_rise_cyc = -1;
  int          we_double = 0;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .MAX_WORDS (256),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .err          (err),
    .frame_err    (frame_err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      wr_addr_q.delete();
      wr_data_q.delete();
      last_we_cyc   <= -1;
      done_rise_cyc <= -1;
      we_double     <= 0;
      prev_we       <= 1'b0;
      prev_done     <= 1'b0;
    end else begin
      if (im_we) begin
        wr_addr_q.push_back(im_addr);
        wr_data_q.push_back(im_wdata);
        last_we_cyc <= cyc;
        if (prev_we) we_double <= we_double + 1;
      end
      if (done && !prev_done) done_rise_cyc <= cyc;
      prev_we   <= im_we;
      prev_done <= done;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    if (stop_ok) sent_q.push_back(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, $urandom_range(0, 15));
  endtask

  task automatic send_len(input int n);
    send_byte(8'(n), 1'b1, $urandom_range(0, 15));
    send_byte(8'(n >> 8), 1'b1, $urandom_range(0, 15));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    sent_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"},    32'(im_we), 32'd0);
    check({tag, "_addr"},  im_addr, 32'd0);
    check({tag, "_wdata"}, im_wdata, 32'd0);
    check({tag, "_crst"},  32'(core_reset), 32'd1);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_wl"},    32'(words_loaded), 32'd0);
  endtask

  // Reference: interpret the accepted byte stream as header + little-endian words
  task automatic check_session(input string tag);
    int          nb, n, nw;
    logic        exp_done, exp_err;
    logic [31:0] words[$];
    repeat (30) @(negedge clk);
    nb = sent_q.size();
    n = -1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (nb >= 2) begin
      n = int'(sent_q[0]) + 256 * int'(sent_q[1]);
      if (n == 0) exp_done = 1'b1;
      else if (n > 256) exp_err = 1'b1;
      else begin
        for (int i = 0; i < n; i++)
          if (5 + 4 * i < nb)
            words.push_back({sent_q[5 + 4*i], sent_q[4 + 4*i], sent_q[3 + 4*i], sent_q[2 + 4*i]});
        exp_done = (words.size() == n);
      end
    end
    nw = words.size();
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], words[i]);
    end
    check({tag, "_wl"},      32'(words_loaded), 32'(nw));
    check({tag, "_done"},    32'(done), 32'(exp_done));
    check({tag, "_err"},     32'(err), 32'(exp_err));
    check({tag, "_crst"},    32'(core_reset), 32'(!exp_done));
    check({tag, "_we_dbl"},  32'(we_double), 32'd0);
    if (exp_done && n > 0)
      check({tag, "_done_lat"}, 32'(done_rise_cyc - last_we_cyc), 32'd1);
  endtask

  initial begin
    logic [7:0] a, b, c, d;
    int         n;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("rst");
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst_rel");

    // Single-word image
    send_len(1);
    send_word(32'h00500093);
    check_session("t1");

    // Three random words
    do_reset();
    send_len(3);
    for (int i = 0; i < 3; i++) send_word($urandom);
    check_session("t2");

    // Empty image: done within the second header byte's stop bit
    do_reset();
    send_byte(8'h00, 1'b1, 5);
    check("t3_pre_done", 32'(done), 32'd0);
    send_byte(8'h00, 1'b1, 0);
    @(negedge clk);
    check("t3_done_now", 32'(done), 32'd1);
    check_session("t3");

    // Oversize length rejected; further bytes ignored
    do_reset();
    send_len(257);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1, $urandom_range(0, 15));
    check_session("t4");
    check("t4_ferr", 32'(frame_err), 32'd0);

    // Start-bit glitch, then a framing error inside a word
    do_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_glitch_ferr", 32'(frame_err), 32'd0);
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    send_len(1);
    send_byte(a, 1'b1, 3);
    send_byte(b, 1'b1, 3);
    send_byte(8'($urandom), 1'b0, DIV * 2);
    check("t5_ferr", 32'(frame_err), 32'd1);
    check("t5_nowrite", 32'(wr_addr_q.size()), 32'd0);
    send_byte(c, 1'b1, 3);
    send_byte(d, 1'b1, 3);
    check_session("t5");
    check("t5_word", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hdeadbeef, {d, c, b, a});
    check("t5_ferr_sticky", 32'(frame_err), 32'd1);

    // Reset in the middle of a session
    do_reset();
    send_len(4);
    send_word($urandom);
    send_word($urandom);
    check_session("t6_part");
    @(negedge clk);
    reset = 1'b1;
    sent_q.delete();
    repeat (2) @(negedge clk);
    check_idle("t6_in_rst");
    reset = 1'b0;
    @(negedge clk);
    check_idle("t6_after");
    send_len(1);
    send_word($urandom);
    check_session("t6_new");

    // Random-length sessions
    for (int k = 0; k < 2; k++) begin
      do_reset();
      n = $urandom_range(1, 6);
      send_len(n);
      for (int i = 0; i < n; i++) send_word($urandom);
      check_session($sformatf("t7_%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
